easyaxi_rd_queue: RTL

Read-request outstanding queue for the EasyAXI master: accepts read commands from the master core, holds up to DEEP_NUM in flight, and issues them on the AR channel in round-robin order. It uses the round-robin index arbiter to pick among pending entries. It then collects R beats by ID and returns data and response to the core. It sits directly upstream of the arbiter, driving its request vector, and consumes the arbiter's index.

---
 rtl/easyaxi_rd_queue_pkg.sv | 47 ++++
 rtl/easyaxi_rd_queue_arb.sv | 55 +++++
 rtl/easyaxi_rd_queue.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/easyaxi_rd_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_queue_pkg
// Purpose  : Shared encodings for the EasyAXI read-request queue.
//            - entry state encoding (FREE / PEND / ISSUED)
//            - issue FSM state encoding
//            - AXI response codes
//            - response severity ranking helpers
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package easyaxi_rd_queue_pkg;

  typedef enum logic [1:0] {
    ENT_FREE   = 2'd0,
    ENT_PEND   = 2'd1,
    ENT_ISSUED = 2'd2
  } ent_state_e;

  typedef enum logic [1:0] {
    ISS_IDLE = 2'd0,
    ISS_PICK = 2'd1,
    ISS_SEND = 2'd2
  } iss_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Severity rank: DECERR > SLVERR > EXOKAY > OKAY.
  function automatic logic [1:0] resp_rank(input logic [1:0] resp);
    case (resp)
      RESP_DECERR: return 2'd3;
      RESP_SLVERR: return 2'd2;
      RESP_EXOKAY: return 2'd1;
      default:     return 2'd0;
    endcase
  endfunction

  // Returns the more severe of two responses (ties keep the first).
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (resp_rank(b) > resp_rank(a)) ? b : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/easyaxi_rd_queue_arb.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_queue_arb
// Purpose  : Round-robin index arbiter. When sche_en_i is high, it registers
//            the first set bit of queue_i after the previously granted
//            index, wrapping around. The result is valid on pointer_o in
//            the following cycle.
// Ports    : clk, rst_n      - clock, async active-low reset
//            queue_i         - request vector (one bit per entry)
//            sche_en_i       - schedule strobe
//            pointer_o       - granted index (registered)
// Revision : 1.0 - initial release
// ============================================================================
module easyaxi_rd_queue_arb #(
  parameter  int DEEP_NUM = 8,
  localparam int IDW      = $clog2(DEEP_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DEEP_NUM-1:0] queue_i,
  input  logic                sche_en_i,
  output logic [IDW-1:0]      pointer_o
);

  logic [IDW-1:0] pointer_q;
  logic [IDW-1:0] pointer_d;
  logic [IDW-1:0] cand;

  // Scan from farthest to nearest offset so the nearest requester after
  // the last grant wins. DEEP_NUM is a power of two, so IDW-bit addition
  // wraps exactly; offset DEEP_NUM maps back to the last grant itself.
  always_comb begin
    pointer_d = pointer_q;
    cand      = '0;
    for (int k = DEEP_NUM; k >= 1; k--) begin
      cand = pointer_q + IDW'(k);
      if (queue_i[cand]) begin
        pointer_d = cand;
      end
    end
  end

  // Reset to the last index so the first grant starts from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer_q <= IDW'(DEEP_NUM - 1);
    end else if (sche_en_i) begin
      pointer_q <= pointer_d;
    end
  end

  assign pointer_o = pointer_q;

endmodule
`default_nettype wire

// File: rtl/easyaxi_rd_queue.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_queue
// Purpose  : Outstanding read-request queue for the EasyAXI master. Stores up
//            to DEEP_NUM commands, issues them on AR in round-robin order,
//            and routes R beats back to the core by ID with the stored tag.
// Ports    : clk, rst_n                        - clock, async active-low reset
//            req_valid_i/req_ready_o, req_*_i  - core command
//            ar*_o / arready_i                 - AXI AR channel
//            rvalid_i, rid_i, rdata_i, rresp_i,
//            rlast_i / rready_o                - AXI R channel
//            rd_*_o                            - core return (no backpressure)
//            err_unexp_o                       - pulse on dropped R beat
// Config   : EASYAXI_RD_ERR_ACC_EN - when defined, each entry accumulates the
//            worst rresp and reports it on the rlast beat.
// Revision : 1.0 - initial release
// ============================================================================
module easyaxi_rd_queue
  import easyaxi_rd_queue_pkg::*;
#(
  parameter  int DEEP_NUM = 8,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int TAG_W    = 4,
  localparam int IDW      = $clog2(DEEP_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  // core command
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_len_i,
  input  logic [2:0]        req_size_i,
  input  logic [1:0]        req_burst_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  // AR channel
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [IDW-1:0]    arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  // R channel
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [IDW-1:0]    rid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  // core return
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        rd_resp_o,
  output logic              rd_last_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              err_unexp_o
);

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  ent_state_e        state_q [DEEP_NUM];
  logic [ADDR_W-1:0] addr_q  [DEEP_NUM];
  logic [7:0]        len_q   [DEEP_NUM];
  logic [2:0]        size_q  [DEEP_NUM];
  logic [1:0]        burst_q [DEEP_NUM];
  logic [TAG_W-1:0]  tag_q   [DEEP_NUM];

  logic [DEEP_NUM-1:0] free_vec;
  logic [DEEP_NUM-1:0] pend_vec;

  for (genvar gi = 0; gi < DEEP_NUM; gi++) begin : g_ent_vec
    assign free_vec[gi] = (state_q[gi] == ENT_FREE);
    assign pend_vec[gi] = (state_q[gi] == ENT_PEND);
  end

  // --------------------------------------------------------------------------
  // Allocation: lowest-index FREE entry
  // --------------------------------------------------------------------------
  logic [IDW-1:0] alloc_idx;
  logic           alloc_fire;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEEP_NUM - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_idx = IDW'(i);
      end
    end
  end

  // Ready reflects the state at cycle start, so an entry freed this cycle
  // only becomes allocatable from the next cycle.
  assign req_ready_o = |free_vec;
  assign alloc_fire  = req_valid_i & req_ready_o;

  // --------------------------------------------------------------------------
  // Issue FSM and AR registers
  // --------------------------------------------------------------------------
  iss_state_e        iss_q;
  logic              arvalid_q;
  logic [IDW-1:0]    arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;

  logic           sche_en;
  logic [IDW-1:0] arb_ptr;
  logic           iss_fire;

  assign sche_en  = (iss_q == ISS_IDLE) && (|pend_vec);
  assign iss_fire = (iss_q == ISS_SEND) && arready_i;

  // The PEND vector sampled in IDLE keeps its bits until PICK because only
  // the issue handshake clears PEND, so arb_ptr always names a PEND entry.
  easyaxi_rd_queue_arb #(
    .DEEP_NUM (DEEP_NUM)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .queue_i   (pend_vec),
    .sche_en_i (sche_en),
    .pointer_o (arb_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q     <= ISS_IDLE;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      case (iss_q)
        ISS_IDLE: begin
          if (|pend_vec) begin
            iss_q <= ISS_PICK;
          end
        end
        ISS_PICK: begin
          arid_q    <= arb_ptr;
          araddr_q  <= addr_q[arb_ptr];
          arlen_q   <= len_q[arb_ptr];
          arsize_q  <= size_q[arb_ptr];
          arburst_q <= burst_q[arb_ptr];
          arvalid_q <= 1'b1;
          iss_q     <= ISS_SEND;
        end
        ISS_SEND: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            iss_q     <= ISS_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          iss_q     <= ISS_IDLE;
        end
      endcase
    end
  end

  assign arvalid_o = arvalid_q;
  assign arid_o    = arid_q;
  assign araddr_o  = araddr_q;
  assign arlen_o   = arlen_q;
  assign arsize_o  = arsize_q;
  assign arburst_o = arburst_q;

  // --------------------------------------------------------------------------
  // R channel classification
  // --------------------------------------------------------------------------
  logic       beat_ok;
  logic       beat_bad;
  logic       beat_free;
  logic [1:0] beat_resp;

  assign rready_o  = 1'b1;
  assign beat_ok   = rvalid_i && (state_q[rid_i] == ENT_ISSUED);
  assign beat_bad  = rvalid_i && !beat_ok;
  assign beat_free = beat_ok && rlast_i;

`ifdef EASYAXI_RD_ERR_ACC_EN
  logic [1:0] worst_q [DEEP_NUM];
  logic [1:0] worst_d;

  // The last beat reports the worst response including its own.
  assign worst_d   = resp_worst(worst_q[rid_i], rresp_i);
  assign beat_resp = rlast_i ? worst_d : rresp_i;

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      worst_q[alloc_idx] <= RESP_OKAY;
    end
    if (beat_ok) begin
      worst_q[rid_i] <= worst_d;
    end
  end
`else
  assign beat_resp = rresp_i;
`endif

  // --------------------------------------------------------------------------
  // Entry state and payload
  // --------------------------------------------------------------------------
  // Allocation touches only FREE entries, issue only the PEND entry on AR,
  // and free only an ISSUED entry, so the three writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEEP_NUM; i++) begin
        state_q[i] <= ENT_FREE;
      end
    end else begin
      if (alloc_fire) begin
        state_q[alloc_idx] <= ENT_PEND;
      end
      if (iss_fire) begin
        state_q[arid_q] <= ENT_ISSUED;
      end
      if (beat_free) begin
        state_q[rid_i] <= ENT_FREE;
      end
    end
  end

  // Payload is qualified by entry state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[alloc_idx]  <= req_addr_i;
      len_q[alloc_idx]   <= req_len_i;
      size_q[alloc_idx]  <= req_size_i;
      burst_q[alloc_idx] <= req_burst_i;
      tag_q[alloc_idx]   <= req_tag_i;
    end
  end

  // --------------------------------------------------------------------------
  // Core return registers
  // --------------------------------------------------------------------------
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rd_resp_q;
  logic              rd_last_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic              err_unexp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_resp_q   <= '0;
      rd_last_q   <= 1'b0;
      rd_tag_q    <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      rd_valid_q  <= beat_ok;
      rd_last_q   <= beat_free;
      err_unexp_q <= beat_bad;
      if (beat_ok) begin
        rd_data_q <= rdata_i;
        rd_resp_q <= beat_resp;
        rd_tag_q  <= tag_q[rid_i];
      end
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_resp_o   = rd_resp_q;
  assign rd_last_o   = rd_last_q;
  assign rd_tag_o    = rd_tag_q;
  assign err_unexp_o = err_unexp_q;

endmodule
`default_nettype wire
